// File: rtl/instruction_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader_if
// Description : Byte-stream, write-port and status bundle for instruction_loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_loader_if #(
   parameter int unsigned len = 32
);
   logic           in_start;
   logic [7:0]     in_byte;
   logic           in_byte_valid;
   logic           out_byte_ready;
   logic           out_wr_en;
   logic [len-1:0] out_wr_addr;
   logic [len-1:0] out_wr_data;
   logic           out_loading;
   logic           out_done;
   logic           out_error;
   logic [len-1:0] out_word_count;

   // Environment side: byte source, start control, memory/status sink
   modport master (
      output in_start, in_byte, in_byte_valid,
      input  out_byte_ready, out_wr_en, out_wr_addr, out_wr_data,
      input  out_loading, out_done, out_error, out_word_count
   );

   // Loader side
   modport slave (
      input  in_start, in_byte, in_byte_valid,
      output out_byte_ready, out_wr_en, out_wr_addr, out_wr_data,
      output out_loading, out_done, out_error, out_word_count
   );
endinterface
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Assembles big-endian bytes into instruction words and writes
//               them to instruction memory until the halt word is seen.
//               Define LOADER_CHECKSUM_EN to verify a trailing XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader #(
   parameter int unsigned    len       = 32,
   parameter int unsigned    RAM_DEPTH = 2048,
   parameter logic [len-1:0] HALT_WORD = 32'hFFFFFFFF
) (
   input  wire logic           clk,
   input  wire logic           reset,
   instruction_loader_if.slave bus
);

   localparam int unsigned    c_BYTES    = len / 8;
   localparam int unsigned    c_IDX_W    = $clog2(c_BYTES);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BYTES - 1);
   localparam logic [len-1:0] c_DEPTH    = len'(RAM_DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ASSEMBLE = 3'd1,
      WRITE    = 3'd2,
      CHECK    = 3'd3,
      DONE     = 3'd4,
      ERROR    = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [c_IDX_W-1:0]   r_byte_idx;
   logic [len-1:0]       r_word;
   logic [len-1:0]       r_wr_addr;
   logic [len-1:0]       r_wr_data;
   logic [len-1:0]       r_count;
   logic                 r_ready;
   logic                 r_wr_en;
   logic                 r_loading;
   logic                 r_done;
   logic                 r_error;
`ifdef LOADER_CHECKSUM_EN
   logic [len-1:0]       r_csum;
`endif

   logic                 w_accept;
   logic                 w_last_byte;
   logic                 w_start;
   logic [len-1:0]       w_word_next;

   // r_ready mirrors the ASSEMBLE/CHECK decode, so it doubles as the accept gate
   assign w_accept    = bus.in_byte_valid & r_ready;
   assign w_last_byte = w_accept && (r_byte_idx == c_LAST_IDX);
   assign w_word_next = {r_word[len-9:0], bus.in_byte};
   assign w_start     = bus.in_start &&
                        ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE, DONE, ERROR: begin
            if (bus.in_start) w_state_next = ASSEMBLE;
         end
         ASSEMBLE: begin
            if (w_last_byte) w_state_next = (r_count == c_DEPTH) ? ERROR : WRITE;
         end
         WRITE: begin
            if (r_wr_data == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
               w_state_next = CHECK;
`else
               w_state_next = DONE;
`endif
            end else begin
               w_state_next = ASSEMBLE;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (w_last_byte) w_state_next = (w_word_next == r_csum) ? DONE : ERROR;
         end
`endif
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Status outputs are decoded from the next state so they line up with r_state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ready   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_loading <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_ready   <= (w_state_next == ASSEMBLE) || (w_state_next == CHECK);
         r_wr_en   <= (w_state_next == WRITE);
         r_loading <= (w_state_next == ASSEMBLE) || (w_state_next == WRITE) ||
                      (w_state_next == CHECK);
         r_done    <= (w_state_next == DONE);
         r_error   <= (w_state_next == ERROR);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_byte_idx <= '0;
         r_word     <= '0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_count    <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else if (w_start) begin
         r_byte_idx <= '0;
         r_word     <= '0;
         r_count    <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_word     <= w_word_next;
            r_byte_idx <= w_last_byte ? '0 : r_byte_idx + 1'b1;
         end
         if ((r_state == ASSEMBLE) && (w_state_next == WRITE)) begin
            r_wr_addr <= r_count << c_IDX_W;
            r_wr_data <= w_word_next;
         end
         if (r_state == WRITE) begin
            r_count <= r_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ r_wr_data;
`endif
         end
      end
   end

   assign bus.out_byte_ready = r_ready;
   assign bus.out_wr_en      = r_wr_en;
   assign bus.out_wr_addr    = r_wr_addr;
   assign bus.out_wr_data    = r_wr_data;
   assign bus.out_loading    = r_loading;
   assign bus.out_done       = r_done;
   assign bus.out_error      = r_error;
   assign bus.out_word_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Directed self-checking bench: cycle-vector table plus overflow,
//               mid-load reset and (with LOADER_CHECKSUM_EN) checksum sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b, valid;
   logic [7:0] din;

   always #5 clk = ~clk;

   instruction_loader_if #(.len(32)) bus_a ();
   instruction_loader_if #(.len(32)) bus_b ();

   assign bus_a.in_start      = start_a;
   assign bus_a.in_byte       = din;
   assign bus_a.in_byte_valid = valid;
   assign bus_b.in_start      = start_b;
   assign bus_b.in_byte       = din;
   assign bus_b.in_byte_valid = valid;

   instruction_loader #(.len(32), .RAM_DEPTH(2048), .HALT_WORD(32'hFFFFFFFF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   instruction_loader #(.len(32), .RAM_DEPTH(4), .HALT_WORD(32'hFFFFFFFF)) dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write-strobe monitors
   logic [31:0] wa_a[$], wd_a[$], wa_b[$], wd_b[$];
   int          long_pulses = 0;
   logic        prev_a = 1'b0, prev_b = 1'b0;

   always @(negedge clk) begin
      if (bus_a.out_wr_en) begin
         wa_a.push_back(bus_a.out_wr_addr);
         wd_a.push_back(bus_a.out_wr_data);
      end
      if (bus_b.out_wr_en) begin
         wa_b.push_back(bus_b.out_wr_addr);
         wd_b.push_back(bus_b.out_wr_data);
      end
      if (bus_a.out_wr_en && prev_a) long_pulses++;
      if (bus_b.out_wr_en && prev_b) long_pulses++;
      prev_a = bus_a.out_wr_en;
      prev_b = bus_b.out_wr_en;
   end

   typedef struct {
      logic        start;
      logic        vld;
      logic [7:0]  din;
      logic        rdy;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic        ld;
      logic        dn;
      logic        er;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic rdy, logic wr,
                               logic [31:0] addr, logic [31:0] data, logic ld,
                               logic dn, logic er, logic [31:0] cnt);
      vec_t r;
      r.start = s;  r.vld = v;   r.din = d;   r.rdy = rdy; r.wr = wr;
      r.addr  = addr; r.data = data; r.ld = ld; r.dn = dn; r.er = er; r.cnt = cnt;
      return r;
   endfunction

   task automatic send_byte(input bit sel, input logic [7:0] b);
      bit ok = 1'b0;
      din   = b;
      valid = 1'b1;
      for (int i = 0; i < 64 && !ok; i++) begin
         ok = sel ? bus_b.out_byte_ready : bus_a.out_byte_ready;
         @(posedge clk);
         @(negedge clk);
      end
      valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_byte timeout: byte %h not accepted, required acceptance", b);
      end
   endtask

   task automatic send_word(input bit sel, input logic [31:0] w);
      send_byte(sel, w[31:24]);
      send_byte(sel, w[23:16]);
      send_byte(sel, w[15:8]);
      send_byte(sel, w[7:0]);
   endtask

   task automatic start_load(input bit sel);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      valid   = 1'b0;
      din     = 8'h00;

      // Cycle table: start, gapped bytes, a byte held across WRITE, start ignored mid-load
      tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'h20, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 8'h08, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'h05, 0, 1, 32'd0, 32'h20080005, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 8'hFF, 1, 0, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 8'hFF, 0, 1, 32'd4, 32'hFFFFFFFF, 1, 0, 0, 1));
`ifdef LOADER_CHECKSUM_EN
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 2));
      tbl.push_back(mk(0, 1, 8'hDF, 1, 0, 0, 0, 1, 0, 0, 2));
      tbl.push_back(mk(0, 1, 8'hF7, 1, 0, 0, 0, 1, 0, 0, 2));
      tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 0, 1, 0, 0, 2));
      tbl.push_back(mk(0, 1, 8'hFA, 0, 0, 0, 0, 0, 1, 0, 2));
`else
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 2));
`endif
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 2));

      #3 reset = 1'b0;
      #1;
      chk("reset ready",   bus_a.out_byte_ready, 0);
      chk("reset wr_en",   bus_a.out_wr_en,      0);
      chk("reset loading", bus_a.out_loading,    0);
      chk("reset done",    bus_a.out_done,       0);
      chk("reset error",   bus_a.out_error,      0);
      chk("reset count",   bus_a.out_word_count, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         start_a = tbl[i].start;
         valid   = tbl[i].vld;
         din     = tbl[i].din;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("row%0d ready", i),   bus_a.out_byte_ready, tbl[i].rdy);
         chk($sformatf("row%0d wr_en", i),   bus_a.out_wr_en,      tbl[i].wr);
         chk($sformatf("row%0d loading", i), bus_a.out_loading,    tbl[i].ld);
         chk($sformatf("row%0d done", i),    bus_a.out_done,       tbl[i].dn);
         chk($sformatf("row%0d error", i),   bus_a.out_error,      tbl[i].er);
         chk($sformatf("row%0d count", i),   bus_a.out_word_count, tbl[i].cnt);
         if (tbl[i].wr) begin
            chk($sformatf("row%0d addr", i), bus_a.out_wr_addr, tbl[i].addr);
            chk($sformatf("row%0d data", i), bus_a.out_wr_data, tbl[i].data);
         end
      end
      start_a = 1'b0;
      valid   = 1'b0;

      // Reset two bytes into the second word, then reload from address 0
      start_load(0);
      send_word(0, 32'h11223344);
      send_byte(0, 8'h55);
      send_byte(0, 8'h66);
      chk("pre-reset count", bus_a.out_word_count, 1);
      #2 reset = 1'b0;
      #1;
      chk("midload ready",   bus_a.out_byte_ready, 0);
      chk("midload wr_en",   bus_a.out_wr_en,      0);
      chk("midload loading", bus_a.out_loading,    0);
      chk("midload count",   bus_a.out_word_count, 0);
      chk("midload addr",    bus_a.out_wr_addr,    0);
      chk("midload data",    bus_a.out_wr_data,    0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      wa_a.delete();
      wd_a.delete();
      start_load(0);
      send_word(0, 32'hAABBCCDD);
      send_word(0, 32'hFFFFFFFF);
`ifdef LOADER_CHECKSUM_EN
      send_word(0, 32'h55443322);
`endif
      repeat (2) @(negedge clk);
      chk("reload writes", wa_a.size(), 2);
      chk("reload addr0", (wa_a.size() > 0) ? wa_a[0] : 32'hDEADBEEF, 32'd0);
      chk("reload data0", (wd_a.size() > 0) ? wd_a[0] : 32'hDEADBEEF, 32'hAABBCCDD);
      chk("reload addr1", (wa_a.size() > 1) ? wa_a[1] : 32'hDEADBEEF, 32'd4);
      chk("reload done",  bus_a.out_done, 1);
      chk("reload count", bus_a.out_word_count, 2);

      // Overflow on the 4-word instance
      start_load(1);
      for (int k = 1; k <= 5; k++) send_word(1, 32'(k));
      repeat (3) @(negedge clk);
      chk("ovf writes", wa_b.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf addr%0d", i), (wa_b.size() > i) ? wa_b[i] : 32'hDEADBEEF, 32'(4 * i));
         chk($sformatf("ovf data%0d", i), (wd_b.size() > i) ? wd_b[i] : 32'hDEADBEEF, 32'(i + 1));
      end
      chk("ovf error",   bus_b.out_error,      1);
      chk("ovf done",    bus_b.out_done,       0);
      chk("ovf loading", bus_b.out_loading,    0);
      chk("ovf ready",   bus_b.out_byte_ready, 0);
      chk("ovf count",   bus_b.out_word_count, 4);

`ifdef LOADER_CHECKSUM_EN
      start_load(0);
      send_word(0, 32'h00000001);
      send_word(0, 32'hFFFFFFFF);
      send_word(0, 32'hFFFFFFFE);
      repeat (2) @(negedge clk);
      chk("csum good done",  bus_a.out_done,  1);
      chk("csum good error", bus_a.out_error, 0);
      start_load(0);
      send_word(0, 32'h00000001);
      send_word(0, 32'hFFFFFFFF);
      send_word(0, 32'h00000000);
      repeat (2) @(negedge clk);
      chk("csum bad done",  bus_a.out_done,  0);
      chk("csum bad error", bus_a.out_error, 1);
`endif

      chk("wr_en pulse width", long_pulses, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
